rdid_reader: RTL and testbench

//  Issues the SPI-flash RDID command (0x9F) and captures the 3-byte JEDEC ID

---
 rtl/rdid_reader.sv | 163 ++++++++++++++++
 tb/tb_rdid_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rdid_reader.sv
`default_nettype none
// rdid_reader: SPI mode-0 master that sends RDID and captures the 3-byte JEDEC ID.
// Build option RDID_AUTO_START_EN launches one read on the first clk after reset.
module rdid_reader #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [7:0]  RDID_CMD = 8'h9F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [7:0] manufacture_id,
    output logic [7:0] memory_type,
    output logic [7:0] memory_capacity
);

    localparam int unsigned         c_div_w   = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0]  c_div_max = c_div_w'(CLK_DIV - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_setup = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_hold  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [c_div_w-1:0] div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic [23:0]        shift_q, shift_d;
    logic               cs_n_q, cs_n_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         mfr_q, mfr_d;
    logic [7:0]         type_q, type_d;
    logic [7:0]         cap_q, cap_d;

    logic               w_tick;
    logic               w_start;
    logic               w_accept;
    logic [5:0]         w_bit_nxt;

`ifdef RDID_AUTO_START_EN
    logic auto_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) auto_q <= 1'b1;
        else       auto_q <= 1'b0;
    end

    assign w_start = start | auto_q;
`else
    assign w_start = start;
`endif

    assign w_tick    = (div_q == c_div_max);
    // The done cycle is still IDLE, so a request landing there must be masked.
    assign w_accept  = (state_q == c_st_idle) && w_start && !done_q;
    assign w_bit_nxt = bit_q + 6'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_st_idle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mfr_q   <= '0;
            type_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mfr_q   <= mfr_d;
            type_q  <= type_d;
            cap_q   <= cap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:  if (w_accept) state_d = c_st_setup;
            c_st_setup: if (w_tick) state_d = c_st_shift;
            c_st_shift: if (w_tick && sck_q && (bit_q == 6'd31)) state_d = c_st_hold;
            c_st_hold:  if (w_tick) state_d = c_st_idle;
            default:    state_d = c_st_idle;
        endcase
    end

    always_comb begin
        div_d   = (state_q == c_st_idle || w_tick) ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mfr_d   = mfr_q;
        type_d  = type_q;
        cap_d   = cap_q;
        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    cs_n_d = 1'b0;
                    busy_d = 1'b1;
                    mosi_d = RDID_CMD[7];
                    bit_d  = '0;
                end
            end
            c_st_shift: begin
                if (w_tick && !sck_q) begin
                    sck_d = 1'b1;
                    if (bit_q >= 6'd8) shift_d = {shift_q[22:0], spi_miso};
                end else if (w_tick) begin
                    sck_d  = 1'b0;
                    bit_d  = w_bit_nxt;
                    // Bit index 7-k equals ~k over three bits.
                    mosi_d = (w_bit_nxt < 6'd8) ? RDID_CMD[~w_bit_nxt[2:0]] : 1'b0;
                    if (bit_q == 6'd31) cs_n_d = 1'b1;
                end
            end
            c_st_hold: begin
                if (w_tick) begin
                    mfr_d  = shift_q[23:16];
                    type_d = shift_q[15:8];
                    cap_d  = shift_q[7:0];
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign spi_cs_n        = cs_n_q;
    assign spi_sck         = sck_q;
    assign spi_mosi        = mosi_q;
    assign manufacture_id  = mfr_q;
    assign memory_type     = type_q;
    assign memory_capacity = cap_q;

endmodule
`default_nettype wire

// File: tb/tb_rdid_reader.sv
`default_nettype none
// tb_rdid_reader: random-stimulus bench with a behavioural SPI flash and frame monitor.
module tb_rdid_reader;

    localparam int D   = 4;
    localparam int LAT = 66 * D;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, spi_cs_n, spi_sck, spi_mosi, spi_miso;
    logic [7:0] manufacture_id, memory_type, memory_capacity;

    int vectors = 0;
    int miscompares = 0;

    rdid_reader #(.CLK_DIV(D), .RDID_CMD(8'h9F)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .manufacture_id(manufacture_id), .memory_type(memory_type),
        .memory_capacity(memory_capacity)
    );

    always #5 clk = ~clk;

    // Flash model: bit i of the response is presented until the i-th falling SCK.
    logic [31:0] resp = 32'h0;
    int fall_total = 0;
    int base = 0;
    int cs_falls = 0;
    int fidx;
    always @(negedge spi_sck) fall_total++;
    always @(negedge spi_cs_n) begin
        base = fall_total;
        cs_falls++;
    end
    assign fidx     = fall_total - base;
    assign spi_miso = (fidx >= 0 && fidx < 32) ? resp[31 - fidx] : 1'b0;

    int rises = 0;
    int cs_bad = 0;
    logic [31:0] mosi_hist = 32'h0;
    always @(posedge spi_sck) begin
        rises++;
        mosi_hist = {mosi_hist[30:0], spi_mosi};
        if (spi_cs_n) cs_bad++;
    end

    int r0, b0, f0;
    logic [23:0] ids;
    assign ids = {manufacture_id, memory_type, memory_capacity};

    task automatic prep(input logic [23:0] id);
        resp = {8'($urandom), id};
        r0 = rises;
        b0 = cs_bad;
        f0 = cs_falls;
    endtask

    // Entered at the negedge just after the edge that launched the frame.
    task automatic finish_read(input logic [23:0] id, input logic [23:0] prev,
                               input int repulse_at, input logic done_start);
        int  n = 0;
        bit  got = 0;
        bit  busy_ok = 1;
        bit  hold_ok = 1;
        while (!got && n <= LAT + 50) begin
            if (done === 1'b1) begin
                got = 1;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (ids !== prev) hold_ok = 0;
                start = (n == repulse_at);
                @(negedge clk);
                n++;
            end
        end
        vectors++;
        if (!got || n != LAT) begin
            miscompares++;
            $display("FAIL latency: got done=%0d after %0d clks, required %0d", got, n, LAT);
            start = 1'b0;
            return;
        end
        vectors++;
        if (!busy_ok) begin miscompares++; $display("FAIL busy_unbroken: busy dropped before done, required high"); end
        vectors++;
        if (!hold_ok) begin miscompares++; $display("FAIL id_hold: IDs changed before done, required %06h", prev); end
        vectors++;
        if (ids !== id) begin miscompares++; $display("FAIL id_value: got %06h required %06h", ids, id); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %b required 0", busy); end
        vectors++;
        if (rises - r0 != 32) begin miscompares++; $display("FAIL sck_pulses: got %0d required 32", rises - r0); end
        vectors++;
        if (mosi_hist !== 32'h9F00_0000) begin miscompares++; $display("FAIL mosi_bits: got %08h required 9f000000", mosi_hist); end
        vectors++;
        if (cs_falls - f0 != 1) begin miscompares++; $display("FAIL cs_frames: got %0d required 1", cs_falls - f0); end
        vectors++;
        if (cs_bad != b0) begin miscompares++; $display("FAIL cs_low: %0d sck rises with cs_n high, required 0", cs_bad - b0); end
        vectors++;
        if (spi_cs_n !== 1'b1) begin miscompares++; $display("FAIL cs_end: got %b required 1", spi_cs_n); end
        start = done_start;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL done_width: got %b one clk later, required 0", done); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL start_in_done: busy got %b required 0", busy); end
    endtask

    task automatic start_read(input logic [23:0] id, input logic [23:0] prev,
                              input int repulse_at, input logic done_start);
        prep(id);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_read(id, prev, repulse_at, done_start);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({spi_cs_n, spi_sck, spi_mosi, busy, done} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: cs_n/sck/mosi/busy/done got %b required 10000",
                     {spi_cs_n, spi_sck, spi_mosi, busy, done});
        end
        vectors++;
        if (ids !== 24'h0) begin miscompares++; $display("FAIL reset_ids: got %06h required 000000", ids); end
`ifdef RDID_AUTO_START_EN
        prep(24'hEF4018);
        reset = 1'b0;
        @(negedge clk);
        finish_read(24'hEF4018, 24'h0, -1, 1'b0);
`else
        prep(24'h0);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        vectors++;
        if (cs_falls != f0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_auto_start: cs_n falls %0d busy %b, required 0 and 0", cs_falls - f0, busy);
        end
        vectors++;
        if (ids !== 24'h0) begin miscompares++; $display("FAIL idle_ids: got %06h required 000000", ids); end
`endif
    endtask

    task automatic test_reset_mid;
        prep(24'h123456);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({spi_cs_n, spi_sck, busy, done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_ctrl: cs_n/sck/busy/done got %b required 1000",
                     {spi_cs_n, spi_sck, busy, done});
        end
        vectors++;
        if (ids !== 24'h0) begin miscompares++; $display("FAIL midreset_ids: got %06h required 000000", ids); end
        @(negedge clk);
`ifdef RDID_AUTO_START_EN
        prep(24'hEF4018);
        reset = 1'b0;
        @(negedge clk);
        finish_read(24'hEF4018, 24'h0, -1, 1'b0);
`else
        reset = 1'b0;
        @(negedge clk);
        start_read(24'hEF4018, 24'h0, -1, 1'b0);
`endif
    endtask

    task automatic test_second_read;
        start_read(24'hC22017, 24'hEF4018, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        start_read(24'hEF4018, 24'hC22017, 50, 1'b1);
    endtask

    task automatic test_random;
        logic [23:0] prev = 24'hEF4018;
        for (int i = 0; i < 8; i++) begin
            logic [23:0] id = 24'($urandom);
            int rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT - 2)) : -1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_read(id, prev, rp, 1'($urandom_range(0, 1)));
            prev = id;
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid;
        test_second_read;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
